// File: rtl/gate_checker.sv
// gate_checker: on-chip response checker for primitive logic gates.
//   Latches a gate function at start and compares each observed output y
//   against the truth-table value for (a, b). It counts samples and mismatches
//   with saturating counters and records the first failing vector. The run
//   completes once all four {a,b} combinations have been accepted.
//   Optional feature macro: GATE_CHECKER_TIMEOUT_EN adds an idle-cycle abort timer.
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   start, op[2:0]   begin/restart a run, gate function latched at start
//   in_valid/in_ready, in_a, in_b, in_y   sample handshake and sample fields
//   seen_mask[3:0]   bit {a,b} set once that combination was accepted
//   err_count, sample_count   saturating mismatch / accepted-sample counters
//   first_fail_valid, first_fail_vec[2:0]   {a,b,y} of the first mismatch
//   done, pass, timeout   run status
module gate_checker #(
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_a,
   input  logic             in_b,
   input  logic             in_y,
   output logic [3:0]       seen_mask,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] sample_count,
   output logic             first_fail_valid,
   output logic [2:0]       first_fail_vec,
   output logic             done,
   output logic             pass,
   output logic             timeout
);
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
   logic [1:0] state;
   logic [2:0] op_q;
   logic       exp_y, accept, mis, idle_hit;
   logic [3:0] seen_next;
   // ready and done decode straight from the state register, so neither has a path from in_valid
   assign in_ready  = state == RUN;
   assign done      = state == DONE;
   assign pass      = done & (err_count == '0) & ~timeout;
   // a sample arriving with start belongs to the old run and is dropped
   assign accept    = in_valid & in_ready & ~start;
   assign mis       = in_y != exp_y;
   assign seen_next = seen_mask | (4'b0001 << {in_a, in_b});
   always_comb begin
      exp_y = 1'b0;
      case (op_q)
         3'd0: exp_y = in_a & in_b;
         3'd1: exp_y = in_a | in_b;
         3'd2: exp_y = ~(in_a & in_b);
         3'd3: exp_y = ~(in_a | in_b);
         3'd4: exp_y = in_a ^ in_b;
         3'd5: exp_y = ~(in_a ^ in_b);
         3'd6: exp_y = ~in_a;
         default: exp_y = 1'b0;
      endcase
   end
`ifdef GATE_CHECKER_TIMEOUT_EN
   localparam int IW = $clog2(TIMEOUT + 1);
   logic [IW-1:0] idle_cnt;
   // fires on the idle cycle that would bring the counter to TIMEOUT
   assign idle_hit = (state == RUN) & ~start & ~accept & (idle_cnt == IW'(TIMEOUT - 1));
   always_ff @(posedge clk or posedge rst) begin
      if (rst) idle_cnt <= '0;
      else idle_cnt <= (start | accept | (state != RUN)) ? '0 : idle_cnt + 1'b1;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) timeout <= 1'b0;
      else if (start) timeout <= 1'b0;
      else if (idle_hit) timeout <= 1'b1;
   end
`else
   assign idle_hit = 1'b0 && (TIMEOUT != 0);
   assign timeout  = 1'b0;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         op_q             <= '0;
         seen_mask        <= '0;
         err_count        <= '0;
         sample_count     <= '0;
         first_fail_valid <= 1'b0;
         first_fail_vec   <= '0;
      end else if (start) begin
         state            <= RUN;
         op_q             <= op;
         seen_mask        <= '0;
         err_count        <= '0;
         sample_count     <= '0;
         first_fail_valid <= 1'b0;
         first_fail_vec   <= '0;
      end else if (accept) begin
         seen_mask    <= seen_next;
         sample_count <= sample_count + CNT_W'(~&sample_count);
         if (mis) err_count <= err_count + CNT_W'(~&err_count);
         if (mis && !first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_vec   <= {in_a, in_b, in_y};
         end
         if (seen_next == 4'hF) state <= DONE;
      end else if (idle_hit) begin
         state <= DONE;
      end
   end
endmodule

// File: tb/tb_gate_checker.sv
// tb_gate_checker: randomized and directed check of gate_checker against a truth-table reference model.
module tb_gate_checker;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, in_a = 1'b0, in_b = 1'b0, in_y = 1'b0;
   logic [2:0] op = '0;
   logic       rdy_a, ffv_a, done_a, pass_a, to_a, rdy_b, ffv_b, done_b, pass_b, to_b;
   logic [3:0] seen_a, seen_b;
   logic [7:0] err_a, smp_a;
   logic [1:0] err_b, smp_b;
   logic [2:0] ffvec_a, ffvec_b;
   int tests = 0, fails = 0;
`ifdef GATE_CHECKER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   // truth tables indexed by {a,b}, one per op code
   logic [3:0] tt [8] = '{4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b0011, 4'b0000};
   bit m_run, m_done, m_to, m_ffv;
   bit [3:0] m_seen;
   bit [2:0] m_op, m_vec;
   int m_err, m_smp, m_idle;

   always #5 clk = ~clk;

   gate_checker #(.CNT_W(8), .TIMEOUT(8)) u_a (
      .clk(clk), .rst(rst), .start(start), .op(op), .in_valid(in_valid), .in_ready(rdy_a),
      .in_a(in_a), .in_b(in_b), .in_y(in_y), .seen_mask(seen_a), .err_count(err_a),
      .sample_count(smp_a), .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a),
      .done(done_a), .pass(pass_a), .timeout(to_a));
   gate_checker #(.CNT_W(2), .TIMEOUT(8)) u_b (
      .clk(clk), .rst(rst), .start(start), .op(op), .in_valid(in_valid), .in_ready(rdy_b),
      .in_a(in_a), .in_b(in_b), .in_y(in_y), .seen_mask(seen_b), .err_count(err_b),
      .sample_count(smp_b), .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b),
      .done(done_b), .pass(pass_b), .timeout(to_b));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
      end
   endtask

   function automatic int sat(input int v, input int mx);
      return v > mx ? mx : v;
   endfunction

   task automatic model_reset();
      m_run = 0; m_done = 0; m_to = 0; m_ffv = 0; m_seen = 0; m_vec = 0;
      m_err = 0; m_smp = 0; m_idle = 0; m_op = 0;
   endtask

   // applies the rules for one clock edge using the inputs currently driven
   task automatic model_edge();
      if (start) begin
         model_reset();
         m_run = 1; m_op = op;
      end else if (m_run && in_valid) begin
         m_seen[{in_a, in_b}] = 1'b1;
         m_smp++;
         m_idle = 0;
         if (in_y != tt[m_op][{in_a, in_b}]) begin
            m_err++;
            if (!m_ffv) begin m_ffv = 1; m_vec = {in_a, in_b, in_y}; end
         end
         if (m_seen == 4'hF) begin m_run = 0; m_done = 1; end
      end else if (m_run && TO_EN) begin
         m_idle++;
         if (m_idle == 8) begin m_to = 1; m_run = 0; m_done = 1; end
      end
   endtask

   task automatic check_all();
      bit p;
      p = m_done && m_err == 0 && !m_to;
      check("ready_a", rdy_a, m_run);           check("ready_b", rdy_b, m_run);
      check("seen_a", seen_a, m_seen);          check("seen_b", seen_b, m_seen);
      check("err_a", err_a, sat(m_err, 255));   check("err_b", err_b, sat(m_err, 3));
      check("smp_a", smp_a, sat(m_smp, 255));   check("smp_b", smp_b, sat(m_smp, 3));
      check("ffv_a", ffv_a, m_ffv);             check("ffv_b", ffv_b, m_ffv);
      check("ffvec_a", ffvec_a, m_vec);         check("ffvec_b", ffvec_b, m_vec);
      check("done_a", done_a, m_done);          check("done_b", done_b, m_done);
      check("pass_a", pass_a, p);               check("pass_b", pass_b, p);
      check("timeout_a", to_a, m_to);           check("timeout_b", to_b, m_to);
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic run_start(input logic [2:0] o);
      start = 1; op = o;
      tick();
      start = 0;
   endtask

   task automatic send(input logic a, input logic b, input logic y);
      in_valid = 1; in_a = a; in_b = b; in_y = y;
      tick();
      in_valid = 0;
   endtask

   task automatic do_reset();
      rst = 1; start = 0; in_valid = 0;
      #2;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      rst = 0;
   endtask

   initial begin
      model_reset();
      @(posedge clk);
      #1;
      check_all();
      rst = 0;
      // AND with a correct gate
      run_start(3'd0);
      send(0, 0, 0); send(1, 0, 0); send(0, 1, 0); send(1, 1, 1);
      check("and_done", done_a, 1'b1); check("and_pass", pass_a, 1'b1);
      check("and_smp", smp_a, 4);      check("and_seen", seen_a, 4'hF);
      // AND with a faulty 1,1 response
      run_start(3'd0);
      send(0, 0, 0); send(1, 0, 0); send(0, 1, 0); send(1, 1, 0);
      check("andf_err", err_a, 1); check("andf_vec", ffvec_a, 3'b110); check("andf_pass", pass_a, 1'b0);
      // XOR with repeats and valid gaps
      run_start(3'd4);
      repeat (3) send(0, 0, 0);
      tick(); send(1, 0, 1); tick(); send(0, 1, 1); tick();
      check("xor_notdone", done_a, 1'b0);
      send(1, 1, 0);
      check("xor_done", done_a, 1'b1); check("xor_smp", smp_a, 6); check("xor_pass", pass_a, 1'b1);
      // restart from NOR to AND, then reset mid-run
      run_start(3'd3);
      send(0, 0, 1); send(1, 0, 0);
      run_start(3'd0);
      check("rs_smp", smp_a, 0); check("rs_seen", seen_a, 0);
      send(1, 1, 1);
      check("rs_and", err_a, 0);
      do_reset();
      check("rst_ready", rdy_a, 1'b0); check("rst_done", done_a, 1'b0);
      // saturation on the narrow instance
      run_start(3'd7);
      repeat (4) send(1, 1, 1);
      send(0, 0, 1); send(0, 1, 1); send(1, 0, 1);
      check("sat_err_b", err_b, 3); check("sat_err_a", err_a, 7);
      // idle timeout
      run_start(3'd0);
      send(0, 0, 0);
      repeat (7) tick();
      check("to_early", done_a, 1'b0);
      tick();
      check("to_done", done_a, TO_EN); check("to_flag", to_a, TO_EN); check("to_pass", pass_a, 1'b0);
      // random traffic, restarts and resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
            continue;
         end
         start = $urandom_range(0, 29) == 0;
         op = 3'($urandom_range(0, 7));
         in_valid = $urandom_range(0, 9) < 7;
         in_a = 1'($urandom); in_b = 1'($urandom);
         in_y = tt[m_op][{in_a, in_b}] ^ ($urandom_range(0, 4) == 0);
         tick();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
